// File: rtl/discharge_pulse_sequencer.sv
// rtl/discharge_pulse_sequencer.sv - Ton/Toff discharge pulse sequencer feeding i_set_generation
//
// Runs an IDLE -> ON -> OFF cycle. Waveform, Ton and Ip are latched at every
// pulse start and held until the next start, so a host may rewrite its
// registers at any time without disturbing a pulse in flight.
//
// Ports
//   clk, rst_n                system clock, asynchronous active-low reset
//   enable                    level, keep issuing pulses (checked only at start points)
//   abort                     level, ends an ON phase early (ignored outside ON)
//   waveform_in/Ton_in/
//   Toff_in/Ip_in             pulse parameters, sampled at pulse start
//   waveform/Ton_timer/Ip     latched parameters for i_set_generation
//   timer_buck_interleave     ON-phase cycle index 1..Ton, 0 otherwise
//   pulse_on                  high during ON
//   pulse_start/pulse_done    one-cycle strobes on first ON / first OFF cycle
//   aborted                   last ON ended by abort (cleared at next start)
//   busy                      state is not IDLE
//   pulse_cnt                 completed pulses, wraps
module discharge_pulse_sequencer #(
    parameter int CNT_W  = 16,
    parameter int PCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              abort,
    input  logic [CNT_W-1:0]  waveform_in,
    input  logic [CNT_W-1:0]  Ton_in,
    input  logic [CNT_W-1:0]  Toff_in,
    input  logic [CNT_W-1:0]  Ip_in,
    output logic [CNT_W-1:0]  waveform,
    output logic [CNT_W-1:0]  Ton_timer,
    output logic [CNT_W-1:0]  Ip,
    output logic [CNT_W-1:0]  timer_buck_interleave,
    output logic              pulse_on,
    output logic              pulse_start,
    output logic              pulse_done,
    output logic              aborted,
    output logic              busy,
    output logic [PCNT_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wf_q, wf_d;
    logic [CNT_W-1:0]    ton_q, ton_d;
    logic [CNT_W-1:0]    ip_q, ip_d;
    logic [CNT_W-1:0]    toff_q, toff_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    off_cnt_q, off_cnt_d;
    logic                pulse_on_q, pulse_on_d;
    logic                pulse_start_q, pulse_start_d;
    logic                pulse_done_q, pulse_done_d;
    logic                aborted_q, aborted_d;
    logic [PCNT_W-1:0]   cnt_q, cnt_d;

    logic                start_cond;
    logic                do_start;

    assign start_cond = enable && (Ton_in != '0) && (waveform_in != '0);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wf_q          <= '0;
            ton_q         <= '0;
            ip_q          <= '0;
            toff_q        <= '0;
            timer_q       <= '0;
            off_cnt_q     <= '0;
            pulse_on_q    <= 1'b0;
            pulse_start_q <= 1'b0;
            pulse_done_q  <= 1'b0;
            aborted_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            wf_q          <= wf_d;
            ton_q         <= ton_d;
            ip_q          <= ip_d;
            toff_q        <= toff_d;
            timer_q       <= timer_d;
            off_cnt_q     <= off_cnt_d;
            pulse_on_q    <= pulse_on_d;
            pulse_start_q <= pulse_start_d;
            pulse_done_q  <= pulse_done_d;
            aborted_q     <= aborted_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        wf_d          = wf_q;
        ton_d         = ton_q;
        ip_d          = ip_q;
        toff_d        = toff_q;
        timer_d       = timer_q;
        off_cnt_d     = off_cnt_q;
        pulse_on_d    = pulse_on_q;
        pulse_start_d = 1'b0;
        pulse_done_d  = 1'b0;
        aborted_d     = aborted_q;
        cnt_d         = cnt_q;
        do_start      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_cond) begin
                    do_start = 1'b1;
                end
            end
            S_ON: begin
                // Abort wins over the timer end; the compare happens before the
                // increment so Ton = all-ones never overflows the timer.
                if (abort || (timer_q == ton_q)) begin
                    state_d      = S_OFF;
                    timer_d      = '0;
                    pulse_on_d   = 1'b0;
                    pulse_done_d = 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    aborted_d    = abort;
                    off_cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_OFF: begin
                // The full Toff always elapses before enable is looked at again.
                if (off_cnt_q == toff_q) begin
                    if (start_cond) begin
                        do_start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    off_cnt_d = off_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                timer_d    = '0;
                pulse_on_d = 1'b0;
            end
        endcase

        if (do_start) begin
            state_d       = S_ON;
            wf_d          = waveform_in;
            ton_d         = Ton_in;
            ip_d          = Ip_in;
            toff_d        = (Toff_in == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : Toff_in;
            timer_d       = {{(CNT_W-1){1'b0}}, 1'b1};
            pulse_on_d    = 1'b1;
            pulse_start_d = 1'b1;
            aborted_d     = 1'b0;
        end
    end

    // Outputs straight from registers
    always_comb begin
        waveform              = wf_q;
        Ton_timer             = ton_q;
        Ip                    = ip_q;
        timer_buck_interleave = timer_q;
        pulse_on              = pulse_on_q;
        pulse_start           = pulse_start_q;
        pulse_done            = pulse_done_q;
        aborted               = aborted_q;
        busy                  = (state_q != S_IDLE);
        pulse_cnt             = cnt_q;
    end

endmodule

// File: tb/tb_discharge_pulse_sequencer.sv
// tb/tb_discharge_pulse_sequencer.sv - directed self-checking bench for discharge_pulse_sequencer
module tb_discharge_pulse_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] waveform_in = '0;
    logic [15:0] Ton_in = '0;
    logic [15:0] Toff_in = '0;
    logic [15:0] Ip_in = '0;

    logic [15:0] waveform, Ton_timer, Ip, timer;
    logic        pulse_on, pulse_start, pulse_done, aborted, busy;
    logic [15:0] pulse_cnt;

    logic [15:0] s_waveform, s_Ton_timer, s_Ip, s_timer;
    logic        s_pulse_on, s_pulse_start, s_pulse_done, s_aborted, s_busy;
    logic [1:0]  s_pulse_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    discharge_pulse_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
        .waveform_in(waveform_in), .Ton_in(Ton_in), .Toff_in(Toff_in), .Ip_in(Ip_in),
        .waveform(waveform), .Ton_timer(Ton_timer), .Ip(Ip),
        .timer_buck_interleave(timer), .pulse_on(pulse_on), .pulse_start(pulse_start),
        .pulse_done(pulse_done), .aborted(aborted), .busy(busy), .pulse_cnt(pulse_cnt)
    );

    // Narrow pulse counter copy: shows the counter wrapping within a short run.
    discharge_pulse_sequencer #(.CNT_W(16), .PCNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
        .waveform_in(waveform_in), .Ton_in(Ton_in), .Toff_in(Toff_in), .Ip_in(Ip_in),
        .waveform(s_waveform), .Ton_timer(s_Ton_timer), .Ip(s_Ip),
        .timer_buck_interleave(s_timer), .pulse_on(s_pulse_on), .pulse_start(s_pulse_start),
        .pulse_done(s_pulse_done), .aborted(s_aborted), .busy(s_busy), .pulse_cnt(s_pulse_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input logic [15:0] e_timer, input logic e_on,
                             input logic e_start, input logic e_done, input logic e_busy,
                             input logic [15:0] e_cnt);
        chk({tag, ".timer"}, timer, e_timer);
        chk({tag, ".pulse_on"}, pulse_on, e_on);
        chk({tag, ".pulse_start"}, pulse_start, e_start);
        chk({tag, ".pulse_done"}, pulse_done, e_done);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".pulse_cnt"}, pulse_cnt, e_cnt);
    endtask

    initial begin
        // Reset state
        tick(2);
        chk_state("reset", 16'd0, 0, 0, 0, 0, 16'd0);
        chk("reset.waveform", waveform, 0);
        chk("reset.Ip", Ip, 0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_after_reset.busy", busy, 0);

        // 1/2: nominal pulse, parameter change mid-ON
        Ton_in = 16'd4000; Toff_in = 16'd1000; Ip_in = 16'd100; waveform_in = 16'h0002;
        enable = 1'b1;
        tick(1);
        chk_state("p1_first", 16'd1, 1, 1, 0, 1, 16'd0);
        chk("p1_first.Ip", Ip, 100);
        chk("p1_first.waveform", waveform, 16'h0002);
        chk("p1_first.Ton_timer", Ton_timer, 4000);
        chk("p1_first.aborted", aborted, 0);
        tick(1);
        chk_state("p1_second", 16'd2, 1, 0, 0, 1, 16'd0);
        tick(1998);
        chk("p1_mid.timer", timer, 2000);
        Ip_in = 16'd200; waveform_in = 16'h0004;
        tick(1);
        chk("p1_mid.Ip_held", Ip, 100);
        chk("p1_mid.wf_held", waveform, 16'h0002);
        tick(1999);
        chk_state("p1_last_on", 16'd4000, 1, 0, 0, 1, 16'd0);
        tick(1);
        chk_state("p1_done", 16'd0, 0, 0, 1, 1, 16'd1);
        chk("p1_done.aborted", aborted, 0);
        chk("p1_done.Ip_held", Ip, 100);
        tick(1);
        chk_state("p1_off2", 16'd0, 0, 0, 0, 1, 16'd1);
        tick(998);
        chk_state("p1_last_off", 16'd0, 0, 0, 0, 1, 16'd1);
        tick(1);
        chk_state("p2_first", 16'd1, 1, 1, 0, 1, 16'd1);
        chk("p2_first.Ip", Ip, 200);
        chk("p2_first.waveform", waveform, 16'h0004);

        // 3: one-cycle abort at timer=1500
        tick(1499);
        chk("p2_pre_abort.timer", timer, 1500);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk_state("p2_abort", 16'd0, 0, 0, 1, 1, 16'd2);
        chk("p2_abort.aborted", aborted, 1);
        chk("p2_abort.small_cnt", s_pulse_cnt, 2);
        tick(999);
        chk_state("p2_last_off", 16'd0, 0, 0, 0, 1, 16'd2);
        chk("p2_last_off.aborted", aborted, 1);
        tick(1);
        chk_state("p3_first", 16'd1, 1, 1, 0, 1, 16'd2);
        chk("p3_first.aborted", aborted, 0);

        // 4: enable dropped mid-ON
        tick(1999);
        chk("p3_mid.timer", timer, 2000);
        enable = 1'b0;
        tick(2000);
        chk_state("p3_last_on", 16'd4000, 1, 0, 0, 1, 16'd2);
        tick(1);
        chk_state("p3_done", 16'd0, 0, 0, 1, 1, 16'd3);
        tick(999);
        chk_state("p3_last_off", 16'd0, 0, 0, 0, 1, 16'd3);
        tick(1);
        chk_state("p3_idle", 16'd0, 0, 0, 0, 0, 16'd3);
        chk("p3_idle.Ip_kept", Ip, 200);
        chk("p3_idle.Ton_kept", Ton_timer, 4000);
        tick(5);
        chk_state("p3_idle_hold", 16'd0, 0, 0, 0, 0, 16'd3);

        // 5: illegal start values, then Ton=1 / Toff=0
        enable = 1'b1; Ton_in = 16'd0;
        tick(3);
        chk("ton0.busy", busy, 0);
        Ton_in = 16'd1; waveform_in = 16'd0;
        tick(3);
        chk("wf0.busy", busy, 0);
        waveform_in = 16'h0002; Toff_in = 16'd0;
        tick(1);
        chk_state("alt_on1", 16'd1, 1, 1, 0, 1, 16'd3);
        tick(1);
        chk_state("alt_off1", 16'd0, 0, 0, 1, 1, 16'd4);
        chk("alt_off1.small_wrap", s_pulse_cnt, 0);
        tick(1);
        chk_state("alt_on2", 16'd1, 1, 1, 0, 1, 16'd4);
        tick(1);
        chk_state("alt_off2", 16'd0, 0, 0, 1, 1, 16'd5);
        chk("alt_off2.small_cnt", s_pulse_cnt, 1);

        // 6: asynchronous reset mid-ON
        Ton_in = 16'd4000; Toff_in = 16'd1000;
        tick(1);
        chk_state("p6_first", 16'd1, 1, 1, 0, 1, 16'd5);
        tick(2999);
        chk("p6_mid.timer", timer, 3000);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async_reset", 16'd0, 0, 0, 0, 0, 16'd0);
        chk("async_reset.Ip", Ip, 0);
        chk("async_reset.Ton_timer", Ton_timer, 0);
        chk("async_reset.waveform", waveform, 0);
        chk("async_reset.small_cnt", s_pulse_cnt, 0);
        enable = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk_state("post_reset_idle", 16'd0, 0, 0, 0, 0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
